// File: rtl/vga_scaler_ctrl.sv
// vga_scaler_ctrl: 640x480@60 timing generator that scales a stored RGB444 image
// by x1/x2/x4 and fetches pixels from a frame buffer with RD_LAT read latency.
// Build option: define VGA_PAGE_FLIP_EN to enable double-buffer page selection;
// without it the display always reads page 0 and page_active stays low.
module vga_scaler_ctrl #(
  parameter int          RD_LAT     = 1,
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter int          ADDR_W     = 17,
  parameter int          PAGE_SIZE  = 76800,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic              clk_25mhz,
  input  logic              sys_rst_n,
  input  logic [11:0]       pixel_in,
  input  logic [1:0]        scale_mode,
  input  logic              page_sel,
  output logic              hsync,
  output logic              vsync,
  output logic [11:0]       rgb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [10:0]       pixel_x,
  output logic [10:0]       pixel_y,
  output logic              frame_start,
  output logic              page_active
);

  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] H_ACT  = 10'd640;
  localparam logic [9:0] V_ACT  = 10'd480;
  localparam logic [9:0] HS_BEG = 10'd656;
  localparam logic [9:0] HS_END = 10'd751;
  localparam logic [9:0] VS_BEG = 10'd490;
  localparam logic [9:0] VS_END = 10'd491;

  // Side-band stages ahead of the output register; together with the output
  // register they span RD_LAT+2 cycles, matching address + memory + rgb.
  localparam int TAG_STAGES = RD_LAT + 1;

  localparam logic [10:0]       IMG_W_L  = 11'(IMG_W);
  localparam logic [10:0]       IMG_H_L  = 11'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] PAGE_OFF = ADDR_W'(PAGE_SIZE);

  typedef struct packed {
    logic        hs;   // sync asserted (active-high inside the pipe)
    logic        vs;
    logic        act;
    logic        img;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        pg;
  } tag_t;

  logic [9:0]        h_cnt, v_cnt, v_next;
  logic              at_origin;
  logic [1:0]        sh_q, sh_in, sh_eff;
  logic              page_eff;
  logic [9:0]        x_img, y_img, line_mask;
  logic              active, in_img;
  logic [ADDR_W-1:0] row_base, addr_next;
  tag_t              tag_in, tag_out;
  tag_t              tag_pipe [TAG_STAGES];

  assign at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign v_next    = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

  // Raster counters: h wraps every 800 pixels, v advances on each h wrap.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= v_next;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Decode requested scale into a shift; the reserved code behaves as x1.
  always_comb begin
    case (scale_mode)
      2'b01:   sh_in = 2'd1;
      2'b10:   sh_in = 2'd2;
      default: sh_in = 2'd0;
    endcase
  end

  // The origin pixel already uses the newly requested settings.
  assign sh_eff = at_origin ? sh_in : sh_q;

  // Frame settings are sampled only at (0,0) so a frame never mixes scales.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_q <= 2'd0;
    end else if (at_origin) begin
      sh_q <= sh_in;
    end
  end

  // Lines per image row minus one, used to step the row base.
  always_comb begin
    case (sh_q)
      2'd1:    line_mask = 10'd1;
      2'd2:    line_mask = 10'd3;
      default: line_mask = 10'd0;
    endcase
  end

  // Row base tracks (v>>sh)*IMG_W by accumulation instead of a multiplier.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_base <= '0;
    end else if (h_cnt == H_LAST) begin
      if (v_next == 10'd0) begin
        row_base <= '0;
      end else if ((v_next & line_mask) == 10'd0) begin
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  assign x_img  = h_cnt >> sh_eff;
  assign y_img  = v_cnt >> sh_eff;
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_img = active && ({1'b0, x_img} < IMG_W_L) && ({1'b0, y_img} < IMG_H_L);

`ifdef VGA_PAGE_FLIP_EN
  logic page_q;

  assign page_eff  = at_origin ? page_sel : page_q;
  assign addr_next = (page_eff ? PAGE_OFF : '0) + row_base + ADDR_W'(x_img);

  // Displayed page latches with the rest of the frame settings.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      page_q <= 1'b0;
    end else if (at_origin) begin
      page_q <= page_sel;
    end
  end

  // page_active follows the pipelined page so it lines up with rgb.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      page_active <= 1'b0;
    end else begin
      page_active <= tag_out.pg;
    end
  end
`else
  logic unused_cfg;

  assign page_eff    = 1'b0;
  assign addr_next   = row_base + ADDR_W'(x_img);
  assign page_active = 1'b0;
  // Page request, page offset and the constant page tag have no consumer here.
  assign unused_cfg  = page_sel ^ (^PAGE_OFF) ^ tag_out.pg;
`endif

  // Address is issued only for in-image pixels; otherwise it holds.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
    end else begin
      mem_rd_en <= in_img;
      if (in_img) begin
        mem_addr <= addr_next;
      end
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.hs  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    tag_in.vs  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    tag_in.act = active;
    tag_in.img = in_img;
    tag_in.x   = {1'b0, h_cnt};
    tag_in.y   = {1'b0, v_cnt};
    tag_in.fs  = at_origin;
    tag_in.pg  = page_eff;
  end

  // Delay line carrying sync/position flags alongside the memory read.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out = tag_pipe[TAG_STAGES-1];

  // Output register: picks image, border or blank colour and aligns syncs.
  always_ff @(posedge clk_25mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~tag_out.hs;
      vsync       <= ~tag_out.vs;
      pixel_x     <= tag_out.x;
      pixel_y     <= tag_out.y;
      frame_start <= tag_out.fs;
      if (tag_out.act && tag_out.img) begin
        rgb <= pixel_in;
      end else if (tag_out.act) begin
        rgb <= BORDER_RGB;
      end else begin
        rgb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scaler_ctrl.sv
// Bench for vga_scaler_ctrl: vector table, hand-written timing/reset/config
// sequences, and randomized runs checked against a position-based model.
`timescale 1ns/1ps
module tb_vga_scaler_ctrl;

  localparam int          RD_LAT    = 1;
  localparam int          IMG_W     = 320;
  localparam int          IMG_H     = 240;
  localparam int          ADDR_W    = 17;
  localparam int          PAGE_SIZE = 76800;
  localparam logic [11:0] BORDER    = 12'h5A5;
  localparam int          LAT       = RD_LAT + 2;
`ifdef VGA_PAGE_FLIP_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic              clk_25mhz  = 1'b0;
  logic              sys_rst_n  = 1'b0;
  logic [11:0]       pixel_in   = 12'h000;
  logic [1:0]        scale_mode = 2'b00;
  logic              page_sel   = 1'b0;
  logic              hsync, vsync, mem_rd_en, frame_start, page_active;
  logic [11:0]       rgb;
  logic [ADDR_W-1:0] mem_addr;
  logic [10:0]       pixel_x, pixel_y;

  vga_scaler_ctrl #(
    .RD_LAT(RD_LAT), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .PAGE_SIZE(PAGE_SIZE), .BORDER_RGB(BORDER)
  ) dut (
    .clk_25mhz(clk_25mhz), .sys_rst_n(sys_rst_n), .pixel_in(pixel_in),
    .scale_mode(scale_mode), .page_sel(page_sel), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .frame_start(frame_start), .page_active(page_active)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int    checks = 0;
  int    failures = 0;
  int    stream_err = 0;
  string stream_msg = "";
  bit    mem_const = 1'b0;

  function automatic logic [11:0] mem_data(input logic [ADDR_W-1:0] a, input bit cst);
    if (cst) return 12'hABC;
    return 12'(a ^ (a >> 7)) ^ 12'h3C5;
  endfunction

  function automatic int shift_of(input logic [1:0] m);
    case (m)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stream_check(input string name);
    checks++;
    if (stream_err != 0) begin
      failures++;
      $display("FAIL %s: %0d cycles differ from model, first: %s", name, stream_err, stream_msg);
    end
    stream_err = 0;
    stream_msg = "";
  endtask

  // Frame-buffer model: RD_LAT cycles from mem_addr to pixel_in.
  logic [ADDR_W-1:0] addr_hist [RD_LAT];
  initial forever begin
    @(negedge clk_25mhz);
    for (int i = RD_LAT - 1; i > 0; i--) addr_hist[i] = addr_hist[i-1];
    addr_hist[0] = mem_addr;
  end
  initial forever begin
    @(posedge clk_25mhz);
    #1;
    pixel_in = mem_data(addr_hist[RD_LAT-1], mem_const);
  end

  // Reference model: raster position from a cycle count, address by arithmetic.
  typedef struct {
    int                h;
    int                v;
    logic [ADDR_W-1:0] addr;
    bit                rd;
    bit                act;
    bit                img;
    bit                pg;
  } exp_t;

  exp_t              mq[$];
  int                mcount = 0;
  int                msh = 0;
  bit                mpg = 1'b0;
  logic [ADDR_W-1:0] mlast = '0;

  initial forever begin
    @(posedge clk_25mhz or negedge sys_rst_n);
    if (!sys_rst_n) begin
      mq.delete();
      mcount = 0;
      msh = 0;
      mpg = 1'b0;
      mlast = '0;
    end else begin
      exp_t e;
      int   xi, yi;
      e.h = mcount % 800;
      e.v = (mcount / 800) % 525;
      if (e.h == 0 && e.v == 0) begin
        msh = shift_of(scale_mode);
        mpg = PF ? page_sel : 1'b0;
      end
      xi = e.h >> msh;
      yi = e.v >> msh;
      e.act = (e.h < 640) && (e.v < 480);
      e.img = e.act && (xi < IMG_W) && (yi < IMG_H);
      if (e.img) mlast = ADDR_W'((mpg ? PAGE_SIZE : 0) + yi * IMG_W + xi);
      e.addr = mlast;
      e.rd   = e.img;
      e.pg   = mpg;
      mq.push_back(e);
      if (mq.size() > LAT) void'(mq.pop_front());
      mcount++;
    end
  end

  // Cycle monitor: every output compared with the model while out of reset.
  initial forever begin
    @(negedge clk_25mhz);
    if (sys_rst_n && mcount >= 1) begin
      exp_t        m, o;
      logic [11:0] ergb;
      bit          ehs, evs, efs, epg;
      int          ex, ey;
      m = mq[mq.size()-1];
      if (mem_addr !== m.addr || mem_rd_en !== m.rd) begin
        stream_err++;
        if (stream_err == 1)
          stream_msg = $sformatf("addr at (%0d,%0d) got %0d/%b need %0d/%b",
                                 m.h, m.v, mem_addr, mem_rd_en, m.addr, m.rd);
      end
      if (mcount >= LAT) begin
        o    = mq[0];
        ehs  = !(o.h >= 656 && o.h <= 751);
        evs  = !(o.v >= 490 && o.v <= 491);
        ergb = o.act ? (o.img ? mem_data(o.addr, mem_const) : BORDER) : 12'h000;
        efs  = (o.h == 0 && o.v == 0);
        epg  = o.pg;
        ex   = o.h;
        ey   = o.v;
      end else begin
        ehs = 1'b1; evs = 1'b1; ergb = 12'h000; efs = 1'b0; epg = 1'b0; ex = 0; ey = 0;
      end
      if (hsync !== ehs || vsync !== evs || rgb !== ergb || frame_start !== efs ||
          page_active !== epg || int'(pixel_x) != ex || int'(pixel_y) != ey) begin
        stream_err++;
        if (stream_err == 1)
          stream_msg = $sformatf("out at (%0d,%0d) got hs%b vs%b rgb%h fs%b pg%b xy%0d,%0d need hs%b vs%b rgb%h fs%b pg%b",
                                 ex, ey, hsync, vsync, rgb, frame_start, page_active,
                                 pixel_x, pixel_y, ehs, evs, ergb, efs, epg);
      end
    end
  end

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic pg, input bit cst);
    @(negedge clk_25mhz);
    sys_rst_n  = 1'b0;
    scale_mode = mode;
    page_sel   = pg;
    mem_const  = cst;
    repeat (3) @(negedge clk_25mhz);
    sys_rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s hsync", tag), int'(hsync), 1);
    chk($sformatf("%s vsync", tag), int'(vsync), 1);
    chk($sformatf("%s rgb", tag), int'(rgb), 0);
    chk($sformatf("%s mem_addr", tag), int'(mem_addr), 0);
    chk($sformatf("%s mem_rd_en", tag), int'(mem_rd_en), 0);
    chk($sformatf("%s pixel_x", tag), int'(pixel_x), 0);
    chk($sformatf("%s pixel_y", tag), int'(pixel_y), 0);
    chk($sformatf("%s frame_start", tag), int'(frame_start), 0);
    chk($sformatf("%s page_active", tag), int'(page_active), 0);
  endtask

  // Cycles after release until the first hsync fall, bounded.
  task automatic first_hsync_fall(output int at);
    at = -1;
    for (int j = 1; j <= 2000 && at < 0; j++) begin
      tick();
      if (!hsync) at = j;
    end
  endtask

  typedef struct {
    int       h;
    int       v;
    logic [1:0] mode;
    int       addr;
    int       rd;
    int       rgb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int falls[$];
    int lows1, lows2, vlows, fs_cnt, fs_at, at;
    bit prev_hs;

    vecs.push_back('{0,   0, 2'b01, 0,    1, 12'hABC});
    vecs.push_back('{1,   1, 2'b01, 0,    1, 12'hABC});
    vecs.push_back('{2,   2, 2'b01, 321,  1, 12'hABC});
    vecs.push_back('{639, 1, 2'b01, 319,  1, 12'hABC});
    vecs.push_back('{640, 2, 2'b01, 639,  0, 12'h000});
    vecs.push_back('{319, 0, 2'b00, 319,  1, 12'hABC});
    vecs.push_back('{320, 0, 2'b00, 319,  0, 12'h5A5});
    vecs.push_back('{700, 0, 2'b00, 319,  0, 12'h000});
    vecs.push_back('{0,   1, 2'b00, 320,  1, 12'hABC});
    vecs.push_back('{639, 3, 2'b00, 1279, 0, 12'h5A5});
    vecs.push_back('{4,   4, 2'b10, 321,  1, 12'hABC});
    vecs.push_back('{639, 7, 2'b10, 479,  1, 12'hABC});
    vecs.push_back('{5,   2, 2'b11, 645,  1, 12'hABC});

    // Outputs while held in reset from power-up.
    repeat (3) @(negedge clk_25mhz);
    #1;
    check_reset_outputs("por");

    // Vector table: address at the position, colour/coordinates at output.
    foreach (vecs[i]) begin
      int k;
      k = vecs[i].v * 800 + vecs[i].h;
      do_reset(vecs[i].mode, 1'b0, 1'b1);
      ticks(k + 1);
      chk($sformatf("vec%0d mem_addr", i), int'(mem_addr), vecs[i].addr);
      chk($sformatf("vec%0d mem_rd_en", i), int'(mem_rd_en), vecs[i].rd);
      ticks(LAT - 1);
      chk($sformatf("vec%0d rgb", i), int'(rgb), vecs[i].rgb);
      chk($sformatf("vec%0d pixel_x", i), int'(pixel_x), vecs[i].h);
      chk($sformatf("vec%0d pixel_y", i), int'(pixel_y), vecs[i].v);
    end
    stream_check("vector stream");

    // Sync timing over two lines from release.
    do_reset(2'b00, 1'b0, 1'b0);
    lows1 = 0; lows2 = 0; vlows = 0; fs_cnt = 0; fs_at = -1; prev_hs = 1'b1;
    for (int j = 1; j <= 1600; j++) begin
      tick();
      if (prev_hs && !hsync) falls.push_back(j);
      prev_hs = hsync;
      if (!hsync) begin
        if (j <= 800) lows1++;
        else lows2++;
      end
      if (!vsync) vlows++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = j;
      end
    end
    chk("hsync fall count", falls.size(), 2);
    chk("first hsync fall", (falls.size() > 0) ? falls[0] : -1, 659);
    chk("second hsync fall", (falls.size() > 1) ? falls[1] : -1, 1459);
    chk("hsync low line0", lows1, 96);
    chk("hsync low line1", lows2, 96);
    chk("vsync low early lines", vlows, 0);
    chk("frame_start count", fs_cnt, 1);
    chk("frame_start cycle", fs_at, LAT);
    stream_check("timing stream");

    // Asynchronous reset mid-line, then timing restarts from the origin.
    do_reset(2'b00, 1'b0, 1'b0);
    ticks(4300);
    chk("pre-reset mem_addr", int'(mem_addr), 1899);
    chk("pre-reset mem_rd_en", int'(mem_rd_en), 1);
    @(negedge clk_25mhz);
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("midline");
    repeat (2) @(negedge clk_25mhz);
    sys_rst_n = 1'b1;
    first_hsync_fall(at);
    chk("hsync fall after reset", at, 659);
    stream_check("reset stream");

    // Scale change mid-frame must not affect the current frame.
    do_reset(2'b00, 1'b0, 1'b0);
    ticks(1600);
    @(negedge clk_25mhz);
    scale_mode = 2'b10;
    ticks(1605);
    chk("midframe scale addr (4,4)", int'(mem_addr), 1284);
    chk("midframe scale rd (4,4)", int'(mem_rd_en), 1);
    stream_check("scale stream");

    // Page request sampled at the origin; later changes ignored.
    do_reset(2'b00, 1'b1, 1'b0);
    tick();
    chk("page addr (0,0)", int'(mem_addr), PF ? PAGE_SIZE : 0);
    @(negedge clk_25mhz);
    page_sel = 1'b0;
    tick();
    chk("page addr (1,0)", int'(mem_addr), PF ? PAGE_SIZE + 1 : 1);
    ticks(LAT - 2);
    chk("page frame_start", int'(frame_start), 1);
    chk("page_active first rgb", int'(page_active), PF ? 1 : 0);
    chk("page first rgb", int'(rgb), int'(mem_data(PF ? ADDR_W'(PAGE_SIZE) : '0, 1'b0)));
    stream_check("page stream");

    // Randomized inputs toggling mid-frame, one run per initial scale code.
    for (int s = 0; s < 4; s++) begin
      do_reset(2'(s), 1'($urandom), 1'b0);
      repeat (6000) begin
        @(negedge clk_25mhz);
        scale_mode = 2'($urandom);
        page_sel   = 1'($urandom);
      end
      stream_check($sformatf("random stream %0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scaler_ctrl.md
VGA_SCALER_CTRL -- requirements
Module: vga_scaler_ctrl

Interface
REQ-001 Parameter: RD_LAT, 1, frame-buffer read latency in cycles from mem_addr to pixel_in (1..3).
REQ-002 Parameter: IMG_W, 320, stored image width in pixels.
REQ-003 Parameter: IMG_H, 240, stored image height in lines.
REQ-004 Parameter: ADDR_W, 17, mem_addr width.
REQ-005 Parameter: PAGE_SIZE, 76800, word offset of page 1 from page 0.
REQ-006 Parameter: BORDER_RGB, 12'h000, colour driven for active pixels outside the image.
REQ-007 clk_25mhz  in  1  pixel clock.
REQ-008 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 pixel_in  in  12  RGB444 word returned by the frame buffer.
REQ-010 scale_mode  in  2  00 = x1, 01 = x2, 10 = x4, 11 = treated as x1.
REQ-011 page_sel  in  1  requested display page.
REQ-012 hsync, vsync  out  1 each  active-low syncs.
REQ-013 rgb  out  12  pixel colour; 0 outside the active area.
REQ-014 mem_addr  out  ADDR_W  frame-buffer read address.
REQ-015 mem_rd_en  out  1  high when mem_addr is a valid image read.
REQ-016 pixel_x, pixel_y  out  11 each  coordinate of the pixel currently on rgb.
REQ-017 frame_start  out  1  one-cycle pulse when the counters wrap to (0,0).
REQ-018 page_active  out  1  page currently being displayed.

Function
REQ-019 The h counter SHALL run 0..799 and the v counter 0..524; v SHALL increment when h wraps. Active area is h<640, v<480. hsync SHALL be low for h 656..751. vsync SHALL be low for v 490..491.
REQ-020 scale_mode and page_sel SHALL be latched only on the cycle when the counters are at (0,0). Changes mid-frame SHALL take effect from the next frame.
REQ-021 The shift amount sh is 0/1/2 for x1/x2/x4. The image coordinate is (h>>sh, v>>sh).
REQ-022 For an active (h,v) with h>>sh < IMG_W and v>>sh < IMG_H, the block SHALL register mem_addr = page*PAGE_SIZE + (v>>sh)*IMG_W + (h>>sh), truncated to ADDR_W, and set mem_rd_en=1 in the same cycle.
REQ-023 For all other (h,v), mem_rd_en SHALL be 0 and mem_addr SHALL hold its last value.
REQ-024 The row base SHALL be computed incrementally: clear at v=0, add IMG_W every 2^sh lines. No multiplier is permitted.
REQ-025 The block SHALL register pixel_in into rgb RD_LAT cycles after the matching mem_addr. Total latency from counter position to rgb is RD_LAT+2 cycles.
REQ-026 hsync, vsync, the active flag, the in-image flag, pixel_x and pixel_y SHALL be delayed through a pipeline of depth RD_LAT+2 so they align exactly with rgb.
REQ-027 At the rgb output: active and in-image gives rgb=pixel_in; active and not in-image gives rgb=BORDER_RGB; inactive gives rgb=0.
REQ-028 frame_start SHALL be aligned with rgb at (0,0).

Reset
REQ-029 Assertion of sys_rst_n SHALL immediately, at any point including mid-line, set: counters and all pipeline stages to 0; hsync=vsync=1; rgb=0; mem_addr=0; mem_rd_en=0; pixel_x=pixel_y=0; frame_start=0; page_active=0; latched scale=x1.
REQ-030 After release, the first rising edge SHALL start from (0,0). The first frame_start SHALL occur at output RD_LAT+2 cycles later.

Configuration
REQ-031 With VGA_PAGE_FLIP_EN defined, page_sel SHALL be latched per REQ-020, and page_active SHALL reflect the latched value aligned with rgb.
REQ-032 Without VGA_PAGE_FLIP_EN, page SHALL be constant 0, page_sel SHALL be ignored, page_active SHALL be tied 0, and no PAGE_SIZE adder SHALL be instantiated.

Verification
REQ-033 Reset, x1, RD_LAT=1: hsync low exactly 96 cycles per 800-cycle line; vsync low 1600 cycles per 420000-cycle frame; first hsync fall 659 cycles after reset release.
REQ-034 x2, 320x240: (h,v)=(0,0),(1,1),(2,2),(639,479) give mem_addr 0, 0, 321, 76799, each with mem_rd_en=1.
REQ-035 x1, 320x240, pixel_in=12'hABC: (h,v)=(319,0) gives rgb=ABC at output; (320,0) gives mem_rd_en=0 and rgb=BORDER_RGB; (700,0) gives rgb=0.
REQ-036 scale_mode changed 00 to 10 at v=100: addresses for the rest of that frame follow x1; the next frame has (4,4) giving mem_addr 321.
REQ-037 With VGA_PAGE_FLIP_EN, page_sel raised at v=200: the current frame is unaffected; the next frame has (0,0) giving mem_addr 76800, and page_active goes to 1 with its first rgb.
REQ-038 sys_rst_n pulsed low at h=300, v=50: all outputs take reset values within the same cycle; after release, syncs resume with frame timing restarted from (0,0).
